// File: rtl/mem_stage_if.sv
// rtl/mem_stage_if.sv - execute->memory->write-back handshake and bundle signals
interface mem_stage_if;
  logic        ms_allowin;
  logic        es_to_ms_valid;
  logic [31:0] es_pc;
  logic [37:0] es_rf_collect;
  logic        es_mem_req;
  logic        es_res_from_mem;
  logic [4:0]  es_ld_op;
  logic [6:0]  es_to_ms_bus;
  logic        data_sram_data_ok;
  logic [31:0] data_sram_rdata;
  logic        ws_allowin;
  logic        wb_flush;
  logic        ms_to_ws_valid;
  logic [31:0] ms_pc;
  logic [37:0] ms_rf_collect;
  logic [6:0]  ms_to_ws_bus;
  logic [37:0] ms_fwd_collect;
  logic        ms_fwd_blocked;
  logic        ms_exc;

  // Drives the stage: execute, data SRAM and write-back side
  modport master (
    input  ms_allowin, ms_to_ws_valid, ms_pc, ms_rf_collect, ms_to_ws_bus,
           ms_fwd_collect, ms_fwd_blocked, ms_exc,
    output es_to_ms_valid, es_pc, es_rf_collect, es_mem_req, es_res_from_mem,
           es_ld_op, es_to_ms_bus, data_sram_data_ok, data_sram_rdata,
           ws_allowin, wb_flush
  );

  // The memory stage itself
  modport slave (
    output ms_allowin, ms_to_ws_valid, ms_pc, ms_rf_collect, ms_to_ws_bus,
           ms_fwd_collect, ms_fwd_blocked, ms_exc,
    input  es_to_ms_valid, es_pc, es_rf_collect, es_mem_req, es_res_from_mem,
           es_ld_op, es_to_ms_bus, data_sram_data_ok, data_sram_rdata,
           ws_allowin, wb_flush
  );
endinterface

// File: rtl/mem_stage.sv
// rtl/mem_stage.sv - memory-access pipeline stage with load alignment and flush discard
module mem_stage (
  input  logic        clk,
  input  logic        resetn,
  mem_stage_if.slave  io
);

  logic        ms_valid;
  logic [31:0] pc_q;
  logic [37:0] rf_q;
  logic        mem_req_q;
  logic        res_from_mem_q;
  logic [4:0]  ld_op_q;
  logic [6:0]  exc_q;
  logic        buf_valid;
  logic [31:0] buf_data;
  logic [1:0]  discard_cnt;

  logic        resp_live;
  logic        got_data;
  logic        ready_go;
  logic        allowin;
  logic        accept;
  logic [1:0]  inc;
  logic        dec;
  logic [31:0] ld_word;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic [31:0] ld_data;
  logic [31:0] wdata;

  // A response only belongs to the current instruction once all stale ones are drained
  assign resp_live = io.data_sram_data_ok & (discard_cnt == 2'd0);
  assign got_data  = buf_valid | resp_live;
  assign ready_go  = ~mem_req_q | got_data;
  assign allowin   = ~ms_valid | (ready_go & io.ws_allowin);
  assign accept    = allowin & io.es_to_ms_valid;

  // Requests in flight that a flush orphans: the held one and one entering this cycle
  assign inc = {1'b0, ms_valid & mem_req_q & ~got_data}
             + {1'b0, io.es_to_ms_valid & io.es_mem_req & allowin};
  assign dec = io.data_sram_data_ok & (discard_cnt != 2'd0);

  assign ld_word = buf_valid ? buf_data : io.data_sram_rdata;
  assign ld_half = rf_q[1] ? ld_word[31:16] : ld_word[15:0];

  // Byte lane select from the low address bits
  always_comb begin
    ld_byte = ld_word[7:0];
    case (rf_q[1:0])
      2'd1:    ld_byte = ld_word[15:8];
      2'd2:    ld_byte = ld_word[23:16];
      2'd3:    ld_byte = ld_word[31:24];
      default: ld_byte = ld_word[7:0];
    endcase
  end

  // Extend the selected lane according to the one-hot load type {w, h, hu, b, bu}
  always_comb begin
    ld_data = 32'd0;
    if (ld_op_q[4])      ld_data = ld_word;
    else if (ld_op_q[3]) ld_data = {{16{ld_half[15]}}, ld_half};
    else if (ld_op_q[2]) ld_data = {16'd0, ld_half};
    else if (ld_op_q[1]) ld_data = {{24{ld_byte[7]}}, ld_byte};
    else if (ld_op_q[0]) ld_data = {24'd0, ld_byte};
  end

  assign wdata = res_from_mem_q ? ld_data : rf_q[31:0];

  assign io.ms_allowin     = allowin;
  assign io.ms_to_ws_valid = ms_valid & ready_go & ~io.wb_flush;
  assign io.ms_pc          = pc_q;
  assign io.ms_rf_collect  = {rf_q[37:32], wdata};
  assign io.ms_to_ws_bus   = exc_q;
  assign io.ms_fwd_collect = {rf_q[37] & ms_valid, rf_q[36:32], wdata};
  assign io.ms_fwd_blocked = ms_valid & res_from_mem_q & ~got_data;
  assign io.ms_exc         = ms_valid & (|exc_q);

  // Valid bit, response buffer and stale-response counter
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      ms_valid    <= 1'b0;
      buf_valid   <= 1'b0;
      buf_data    <= 32'd0;
      discard_cnt <= 2'd0;
    end else begin
      if (io.wb_flush) begin
        ms_valid  <= 1'b0;
        buf_valid <= 1'b0;
      end else if (allowin) begin
        ms_valid  <= io.es_to_ms_valid;
        buf_valid <= 1'b0;
      end else if (resp_live & ms_valid & mem_req_q & ~buf_valid & ~io.ws_allowin) begin
        buf_valid <= 1'b1;
        buf_data  <= io.data_sram_rdata;
      end
      if (io.wb_flush) discard_cnt <= discard_cnt + inc - {1'b0, dec};
      else             discard_cnt <= discard_cnt - {1'b0, dec};
    end
  end

  // Capture the instruction offered by execute
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      pc_q           <= 32'd0;
      rf_q           <= 38'd0;
      mem_req_q      <= 1'b0;
      res_from_mem_q <= 1'b0;
      ld_op_q        <= 5'd0;
      exc_q          <= 7'd0;
    end else if (accept) begin
      pc_q           <= io.es_pc;
      rf_q           <= io.es_rf_collect;
      mem_req_q      <= io.es_mem_req;
      res_from_mem_q <= io.es_res_from_mem;
      ld_op_q        <= io.es_ld_op;
      exc_q          <= io.es_to_ms_bus;
    end
  end

endmodule
